// File: rtl/enigma_pkg.sv
// Shared constants, wiring/notch tables and mod-26 helpers for the Enigma rotor datapath.
// Wiring tables are ASCII strings packed MSB-first, so letter index i sits at byte (ALPHA-1-i).
package enigma_pkg;

    localparam int unsigned ALPHA       = 26;
    localparam int unsigned ASCII_A     = 65;
    localparam int unsigned ASCII_LA    = 97;
    localparam int unsigned IDX_W       = 5;
    localparam int unsigned NUM_ROTORS  = 5;
    localparam int unsigned ROTOR_SEL_W = 3;

    typedef logic [IDX_W-1:0]   idx_t;
    typedef logic [ALPHA*8-1:0] wiring_str_t;

    typedef struct packed {
        idx_t pos;
        idx_t ring;
    } rotor_cfg_t;

    localparam wiring_str_t WIRING_FWD [NUM_ROTORS] = '{
        "EKMFLGDQVZNTOWYHXUSPAIBRCJ",
        "AJDKSIRUXBLHWTMCQGZNPYFVOE",
        "BDFHJLCPRTXVZNYEIWGAKMUSQO",
        "ESOVPZJAYQUIRHXLNFTGKMCDBW",
        "VZBRGITYUPSDNKLQOXHMCEWFAJ"
    };

    localparam wiring_str_t WIRING_INV [NUM_ROTORS] = '{
        "UWYGADFPVZBECKMTHXSLRINQOJ",
        "AJPCZWRLFBDKOTYUQGENHXMIVS",
        "TAGBPCSDQEUFVNZHYIXJWLRKOM",
        "HYWXARTNLGUPVQCEJMBSKDZOIF",
        "YCULVXESFZNOTMQJPDKGIAWRHB"
    };

    localparam idx_t NOTCH [NUM_ROTORS] = '{5'd16, 5'd4, 5'd21, 5'd9, 5'd25};

    function automatic idx_t letter_to_idx(input logic [7:0] c);
        return IDX_W'(c - 8'(ASCII_A));
    endfunction

    // (a + b) mod 26 for a, b in 0..25
    function automatic idx_t mod26_add(input idx_t a, input idx_t b);
        logic [IDX_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (IDX_W+1)'(ALPHA)) s = s - (IDX_W+1)'(ALPHA);
        return s[IDX_W-1:0];
    endfunction

    // (a - b) mod 26 for a, b in 0..25; the wrapped difference is corrected by +26
    function automatic idx_t mod26_sub(input idx_t a, input idx_t b);
        logic [IDX_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (a < b) d = d + (IDX_W+1)'(ALPHA);
        return d[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/enigma_wiring_lut.sv
// Combinational rotor wiring lookup: (rotor, direction, contact index) -> contact index.
module enigma_wiring_lut
    import enigma_pkg::*;
(
    input  logic [ROTOR_SEL_W-1:0] rotor_id_i,
    input  logic                   dir_i,
    input  idx_t                   idx_i,
    output idx_t                   map_c_o
);

    wiring_str_t row_c;

    always_comb begin
        row_c = WIRING_FWD[0];
        for (int unsigned r = 0; r < NUM_ROTORS; r++) begin
            if (rotor_id_i == ROTOR_SEL_W'(r)) begin
                row_c = dir_i ? WIRING_INV[r] : WIRING_FWD[r];
            end
        end
    end

    always_comb begin
        map_c_o = '0;
        for (int unsigned i = 0; i < ALPHA; i++) begin
            if (idx_i == IDX_W'(i)) begin
                map_c_o = letter_to_idx(row_c[8*(ALPHA-1-i) +: 8]);
            end
        end
    end

endmodule

// File: rtl/enigma_rotor_stage.sv
// Single Enigma rotor stage: position/ring registers, stepping with notch carry,
// and a one-cycle registered forward/inverse letter translation.
module enigma_rotor_stage
    import enigma_pkg::*;
#(
    parameter int unsigned ROTOR_ID = 0,
    parameter int unsigned CHAR_W   = 16,
    parameter bit          LOWER_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_load,
    input  logic [IDX_W-1:0]  cfg_pos,
    input  logic [IDX_W-1:0]  cfg_ring,
    input  logic              step_in,
    input  logic              in_valid,
    input  logic              in_dir,
    input  logic [CHAR_W-1:0] in_char,
    output logic              out_valid,
    output logic [CHAR_W-1:0] out_char,
    output logic              out_err,
    output logic              carry_out,
    output logic              at_notch,
    output logic [IDX_W-1:0]  pos
);

    localparam idx_t NOTCH_POS = NOTCH[ROTOR_ID];
    localparam idx_t LAST_POS  = IDX_W'(ALPHA - 1);

    rotor_cfg_t        cfg_q, cfg_d;
    logic              carry_q, carry_d;
    logic              out_valid_q, out_valid_d;
    logic              out_err_q, out_err_d;
    logic [CHAR_W-1:0] out_char_q, out_char_d;

    logic is_upper_c, is_lower_c, legal_c;
    idx_t in_idx_c, s_idx_c, w_idx_c, r_idx_c;

    // Letter decode; any nonzero upper bit pushes the code out of both ranges
    always_comb begin
        is_upper_c = (in_char >= CHAR_W'(ASCII_A)) &&
                     (in_char <= CHAR_W'(ASCII_A + ALPHA - 1));
        is_lower_c = LOWER_EN &&
                     (in_char >= CHAR_W'(ASCII_LA)) &&
                     (in_char <= CHAR_W'(ASCII_LA + ALPHA - 1));
        legal_c    = is_upper_c || is_lower_c;
        in_idx_c   = is_lower_c ? IDX_W'(in_char - CHAR_W'(ASCII_LA))
                                : IDX_W'(in_char - CHAR_W'(ASCII_A));
        s_idx_c    = mod26_sub(mod26_add(in_idx_c, cfg_q.pos), cfg_q.ring);
    end

    enigma_wiring_lut u_lut (
        .rotor_id_i (ROTOR_SEL_W'(ROTOR_ID)),
        .dir_i      (in_dir),
        .idx_i      (s_idx_c),
        .map_c_o    (w_idx_c)
    );

    assign r_idx_c = mod26_add(mod26_sub(w_idx_c, cfg_q.pos), cfg_q.ring);

    // Translation always uses the pre-update position/ring held in cfg_q
    always_comb begin
        cfg_d       = cfg_q;
        carry_d     = 1'b0;
        out_valid_d = in_valid;
        out_char_d  = out_char_q;
        out_err_d   = out_err_q;

        if (cfg_load) begin
            cfg_d.pos  = cfg_pos;
            cfg_d.ring = cfg_ring;
        end else if (step_in) begin
            cfg_d.pos = (cfg_q.pos == LAST_POS) ? '0 : cfg_q.pos + IDX_W'(1);
            carry_d   = (cfg_q.pos == NOTCH_POS);
        end

        if (in_valid) begin
            if (legal_c) begin
                out_char_d = CHAR_W'(r_idx_c) + CHAR_W'(ASCII_A);
                out_err_d  = 1'b0;
            end else begin
                out_char_d = in_char;
                out_err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_char_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            cfg_q       <= cfg_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            out_char_q  <= out_char_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_char  = out_char_q;
    assign out_err   = out_err_q;
    assign carry_out = carry_q;
    assign pos       = cfg_q.pos;
    assign at_notch  = (cfg_q.pos == NOTCH_POS);

endmodule

// File: tb/tb_enigma_rotor_stage.sv
// Bench for enigma_rotor_stage: all five rotors driven in parallel, results scoreboarded
// against a letter-level Enigma rotor model.
module tb_enigma_rotor_stage;

    localparam int unsigned NR = 5;
    localparam int unsigned CW = 16;
    localparam int NOTCH_TB [NR] = '{16, 4, 21, 9, 25};

    string fwd_s [NR] = '{
        "EKMFLGDQVZNTOWYHXUSPAIBRCJ",
        "AJDKSIRUXBLHWTMCQGZNPYFVOE",
        "BDFHJLCPRTXVZNYEIWGAKMUSQO",
        "ESOVPZJAYQUIRHXLNFTGKMCDBW",
        "VZBRGITYUPSDNKLQOXHMCEWFAJ"
    };

    typedef struct packed {
        logic [CW-1:0] ch;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, cfg_load, step_in, in_valid, in_dir;
    logic [4:0]    cfg_pos, cfg_ring;
    logic [CW-1:0] in_char;

    logic          out_valid_w [NR];
    logic [CW-1:0] out_char_w  [NR];
    logic          out_err_w   [NR];
    logic          carry_w     [NR];
    logic          at_notch_w  [NR];
    logic [4:0]    pos_w       [NR];

    exp_t          exp_q [NR][$];

    int            checks = 0;
    int            errors = 0;

    int            m_pos, m_ring;
    logic          m_valid;
    logic [CW-1:0] m_char  [NR];
    logic          m_err   [NR];
    logic          m_carry [NR];

    always #5 clk = ~clk;

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s rotor%0d got %0d expected %0d", name, g, act, exp_v);
        end
    endtask

    for (genvar g = 0; g < NR; g++) begin : g_dut
        enigma_rotor_stage #(
            .ROTOR_ID (g),
            .CHAR_W   (CW),
            .LOWER_EN (1'b1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .cfg_load  (cfg_load),
            .cfg_pos   (cfg_pos),
            .cfg_ring  (cfg_ring),
            .step_in   (step_in),
            .in_valid  (in_valid),
            .in_dir    (in_dir),
            .in_char   (in_char),
            .out_valid (out_valid_w[g]),
            .out_char  (out_char_w[g]),
            .out_err   (out_err_w[g]),
            .carry_out (carry_w[g]),
            .at_notch  (at_notch_w[g]),
            .pos       (pos_w[g])
        );

        exp_t mon_e;

        // Scoreboard monitor: pops one expected result per presented output
        always @(negedge clk) begin
            if (out_valid_w[g] === 1'b1) begin
                if (exp_q[g].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected rotor%0d got char %0d expected no output", g, out_char_w[g]);
                end else begin
                    mon_e = exp_q[g].pop_front();
                    chk("sb_char", g, 32'(out_char_w[g]), 32'(mon_e.ch));
                    chk("sb_err",  g, 32'(out_err_w[g]),  32'(mon_e.err));
                end
            end
        end
    end

    function automatic int char_idx(input logic [CW-1:0] c);
        int ci;
        ci = int'(c);
        if (ci >= 65 && ci <= 90)  return ci - 65;
        if (ci >= 97 && ci <= 122) return ci - 97;
        return -1;
    endfunction

    // Rotor model: shift into rotor frame, look up wiring (or search it for the inverse), shift back
    function automatic exp_t model(input int r, input logic dir, input logic [CW-1:0] c,
                                   input int p, input int rg);
        exp_t e;
        int idx, s, w, o;
        idx = char_idx(c);
        if (idx < 0) begin
            e.ch  = c;
            e.err = 1'b1;
            return e;
        end
        s = (idx + p - rg + 26) % 26;
        w = 0;
        if (!dir) begin
            w = int'(fwd_s[r].getc(s)) - 65;
        end else begin
            for (int k = 0; k < 26; k++) begin
                if (int'(fwd_s[r].getc(k)) - 65 == s) w = k;
            end
        end
        o = (w - p + rg + 26) % 26;
        e.ch  = CW'(o + 65);
        e.err = 1'b0;
        return e;
    endfunction

    task automatic check_state();
        for (int g = 0; g < NR; g++) begin
            chk("pos",       g, 32'(pos_w[g]),       32'(m_pos));
            chk("carry_out", g, 32'(carry_w[g]),     32'(m_carry[g]));
            chk("at_notch",  g, 32'(at_notch_w[g]),  32'(m_pos == NOTCH_TB[g]));
            chk("out_valid", g, 32'(out_valid_w[g]), 32'(m_valid));
            chk("out_char",  g, 32'(out_char_w[g]),  32'(m_char[g]));
            chk("out_err",   g, 32'(out_err_w[g]),   32'(m_err[g]));
        end
    endtask

    // One clock of stimulus, applied just after an active edge; checks state after the next edge
    task automatic cycle(input logic r, input logic ld, input logic [4:0] cp, input logic [4:0] cr,
                         input logic st, input logic v, input logic d, input logic [CW-1:0] ch);
        exp_t e;
        rst      = r;
        cfg_load = ld;
        cfg_pos  = cp;
        cfg_ring = cr;
        step_in  = st;
        in_valid = v;
        in_dir   = d;
        in_char  = ch;
        for (int g = 0; g < NR; g++) begin
            if (r) begin
                m_char[g] = '0;
                m_err[g]  = 1'b0;
            end else if (v) begin
                e = model(g, d, ch, m_pos, m_ring);
                exp_q[g].push_back(e);
                m_char[g] = e.ch;
                m_err[g]  = e.err;
            end
            m_carry[g] = !r && !ld && st && (m_pos == NOTCH_TB[g]);
        end
        m_valid = v && !r;
        if (r) begin
            m_pos  = 0;
            m_ring = 0;
        end else if (ld) begin
            m_pos  = int'(cp);
            m_ring = int'(cr);
        end else if (st) begin
            m_pos = (m_pos + 1) % 26;
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic load(input logic [4:0] p, input logic [4:0] rg);
        cycle(1'b0, 1'b1, p, rg, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic send(input logic d, input logic [CW-1:0] ch);
        cycle(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, d, ch);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [CW-1:0] rc;
        int kind;

        rst = 1'b1; cfg_load = 1'b0; step_in = 1'b0; in_valid = 1'b0; in_dir = 1'b0;
        cfg_pos = '0; cfg_ring = '0; in_char = '0;
        m_pos = 0; m_ring = 0; m_valid = 1'b0;
        for (int g = 0; g < NR; g++) begin
            m_char[g] = '0; m_err[g] = 1'b0; m_carry[g] = 1'b0;
        end

        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, CW'(65));

        // Rotor I reference vectors
        load(5'd0, 5'd0);
        send(1'b0, CW'(65));
        chk("tp_A_fwd", 0, 32'(out_char_w[0]), 32'd69);
        send(1'b1, CW'(69));
        chk("tp_E_inv", 0, 32'(out_char_w[0]), 32'd65);
        load(5'd1, 5'd0);
        send(1'b0, CW'(65));
        chk("tp_pos1", 0, 32'(out_char_w[0]), 32'd74);
        load(5'd0, 5'd1);
        send(1'b0, CW'(65));
        chk("tp_ring1", 0, 32'(out_char_w[0]), 32'd75);

        // Notch carry and wrap
        load(5'd16, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, '0);
        chk("tp_carry_q", 0, 32'(carry_w[0]), 32'd1);
        cycle(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, '0);
        chk("tp_carry_r", 0, 32'(carry_w[0]), 32'd0);
        load(5'd25, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, '0);
        chk("tp_wrap_pos", 0, 32'(pos_w[0]), 32'd0);

        // Illegal and lowercase input
        send(1'b0, CW'(64));
        chk("tp_at_err", 0, 32'(out_err_w[0]), 32'd1);
        send(1'b0, CW'(97));
        chk("tp_lower_a", 0, 32'(out_char_w[0]), 32'd69);
        send(1'b0, 16'h0141);
        send(1'b1, CW'(123));

        // Translate and step together, then load overriding step
        load(5'd0, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, CW'(65));
        chk("tp_pre_step", 0, 32'(out_char_w[0]), 32'd69);
        send(1'b0, CW'(65));
        chk("tp_post_step", 0, 32'(out_char_w[0]), 32'd74);
        load(5'd4, 5'd0);
        cycle(1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, '0);
        chk("tp_load_over_step", 1, 32'(carry_w[1]), 32'd0);

        // Reset mid-stream
        send(1'b0, CW'(66));
        cycle(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, CW'(67));
        idle();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 5)      rc = CW'(65 + $urandom_range(0, 25));
            else if (kind <= 7) rc = CW'(97 + $urandom_range(0, 25));
            else if (kind == 8) rc = CW'($urandom_range(0, 255));
            else                rc = CW'($urandom);
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 19) == 0),
                  5'($urandom_range(0, 25)),
                  5'($urandom_range(0, 25)),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 1)),
                  rc);
        end

        idle();
        idle();
        for (int g = 0; g < NR; g++) begin
            chk("queue_drain", g, 32'(exp_q[g].size()), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
